// File: rtl/sb_pkg.sv
// sb_pkg: shared states, default sizes and saturating increment for the scoreboard check controller
package sb_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} sb_state_e;
  localparam int SB_CNTW    = 16;
  localparam int SB_TIMEOUT = 1024;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = 32'hffff_ffff >> (32 - w);
    return (v == lim) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/sb_rr_arb.sv
// sb_rr_arb: round-robin arbiter granting the first request at or after the pointer, wrapping
module sb_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] ptr;
  // search from the pointer for the first active request
  always_comb begin
    int j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && req[j] && !found) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
        found    = 1'b1;
      end
    end
  end
  // move past the winner only when its word was actually taken
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ptr <= '0;
    else if (adv) ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/sb_check_ctrl.sv
// sb_check_ctrl: arbitrates producer pushes into a shared scoreboard, checks observed words, drains at end of test (optional SB_CHECK_STOP_EN stops simulation on error/timeout)
module sb_check_ctrl
  import sb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int CNTW    = SB_CNTW,
  parameter int TIMEOUT = SB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       exp_valid,
  input  logic [NREQ*WIDTH-1:0] exp_data,
  output logic [NREQ-1:0]       exp_ready,
  output logic                  sb_push,
  output logic [WIDTH-1:0]      sb_din,
  output logic                  sb_pop,
  input  logic [WIDTH-1:0]      sb_dout,
  input  logic                  sb_empty,
  input  logic                  sb_full,
  input  logic                  obs_valid,
  input  logic [WIDTH-1:0]      obs_data,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CNTW-1:0]       match_cnt,
  output logic [CNTW-1:0]       err_cnt,
  output logic [CNTW-1:0]       left_cnt,
  output logic                  mismatch,
  output logic [WIDTH-1:0]      err_exp,
  output logic [WIDTH-1:0]      err_obs,
  output logic                  timeout
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  sb_state_e state, state_n;
  logic st_run, st_drain, hit, miss, bad_obs;
  logic [IW-1:0] gidx;
  logic [TW-1:0] tcnt, tcnt_n;
  sb_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (exp_valid),
    .en    (st_run && !sb_full),
    .adv   (sb_push),
    .grant (exp_ready),
    .idx   (gidx)
  );
  assign sb_push = |(exp_valid & exp_ready);
  assign sb_din  = exp_data[int'(gidx)*WIDTH +: WIDTH];
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= RUN;
    else state <= state_n;
  // drain only starts from RUN; DONE is left only through reset
  always_comb
    state_n = (state == RUN && drain_req) ? DRAIN :
              (state == DRAIN && sb_empty) ? DONE : state;
  // pops, drain completion, compare outcome and stall count
  always_comb begin
    st_run     = state == RUN;
    st_drain   = state == DRAIN;
    sb_pop     = (st_run ? obs_valid : st_drain) && !sb_empty;
    drain_done = state == DONE || (st_drain && sb_empty);
    hit        = st_run && obs_valid && !sb_empty && obs_data == sb_dout;
    miss       = st_run && obs_valid && (sb_empty || obs_data != sb_dout);
    bad_obs    = miss || (!st_run && obs_valid);
    tcnt_n     = !st_run ? tcnt :
                 (obs_valid || sb_empty) ? '0 :
                 (int'(tcnt) == TIMEOUT) ? tcnt : tcnt + 1'b1;
  end
  // counters, last-error capture and sticky stall flag
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      match_cnt <= '0;
      err_cnt   <= '0;
      left_cnt  <= '0;
      mismatch  <= 1'b0;
      err_exp   <= '0;
      err_obs   <= '0;
      tcnt      <= '0;
      timeout   <= 1'b0;
    end else begin
      if (hit) match_cnt <= CNTW'(sat_inc(32'(match_cnt), CNTW));
      if (bad_obs) err_cnt <= CNTW'(sat_inc(32'(err_cnt), CNTW));
      if (st_drain && !sb_empty) left_cnt <= CNTW'(sat_inc(32'(left_cnt), CNTW));
      mismatch <= miss;
      if (miss) begin
        err_exp <= sb_empty ? '0 : sb_dout;
        err_obs <= obs_data;
      end
      tcnt    <= tcnt_n;
      timeout <= timeout | (int'(tcnt_n) == TIMEOUT);
    end
`ifdef SB_CHECK_STOP_EN
  // stop the simulation as soon as an error or a stall is flagged
  always @(posedge clk) begin
    if (mismatch) begin
      $display("ERROR: %0t sb_check_ctrl expected %h observed %h", $time, err_exp, err_obs);
      $finish;
    end
    if (timeout) begin
      $display("ERROR: %0t sb_check_ctrl timeout with data pending", $time);
      $finish;
    end
  end
`else
`endif
endmodule
